patch_xfer_master: RTL and testbench
====================================

Name: patch_xfer_master

Overview:
- Bus initiator for the mixer/synth register bus: drives adr/write/read and one-hot section selects (com/osc/m1/m2) toward the per-voice control-data register file.
- Dump: walks every register in fixed order, reads each, and emits the bytes on a valid/ready output stream (patch save, host readback).
- Load: consumes a byte stream in the same order and issues one bus write per byte (patch recall).
- Sits between the MIDI/sysex or host bridge and the mixer control registers.

Parameters:
V_OSC, 4, oscillators per voice; the osc, m1 and m2 sections each span V_OSC*16 addresses.
COM_LEN, 32, number of com-section addresses transferred (0..COM_LEN-1).

Ports:
reg_clk  in  1  register-bus clock; all logic on posedge.
reset_reg_n  in  1  asynchronous active-low reset.
dump_start  in  1  one-cycle pulse; starts a dump when idle.
load_start  in  1  one-cycle pulse; starts a load when idle.
busy  out  1  high from the accepted start until done.
done  out  1  one-cycle pulse when a transfer completes.
dout_data  out  8  dump stream byte.
dout_valid  out  1  dump byte valid.
dout_ready  in  1  downstream accepts the dump byte.
din_data  in  8  load stream byte.
din_valid  in  1  load byte valid.
din_ready  out  1  load byte accepted this cycle.
adr  out  7  register address.
write  out  1  bus write strobe, one cycle per byte.
read  out  1  bus read strobe, one cycle per byte.
com_sel, osc_sel, m1_sel, m2_sel  out  1 each  one-hot section select; all low when idle.
synth_data_out  out  8  write data; drives the responder's synth_data_in.
regdata_in  in  8  read data; the responder latches it on negedge of the read cycle.

Behaviour:
- Reset values: all outputs 0; state IDLE; section counter 0; address counter 0.
- Order: com adr 0..COM_LEN-1, then osc, m1, m2, each adr 0..V_OSC*16-1. Total N = COM_LEN + 3*V_OSC*16 = 224 by default.
- States: IDLE, RD_ISSUE, RD_HOLD, WR_WAIT, WR_ISSUE, FINISH.
- IDLE:
  - dump_start -> RD_ISSUE.
  - load_start -> WR_WAIT.
  - Both asserted in the same cycle: dump wins, load_start ignored.
  - Starts are ignored while busy.
- RD_ISSUE (1 cycle): read=1, sel and adr valid.
- RD_HOLD:
  - On the first RD_HOLD cycle, capture regdata_in into dout_data and set dout_valid=1. Bus read latency is 1 cycle.
  - Hold dout_data/dout_valid stable until dout_ready.
  - On handshake: advance the address; go to RD_ISSUE, or FINISH after the last byte.
  - dout_ready is ignored while dout_valid=0.
- WR_WAIT:
  - din_ready=1 (combinational from state).
  - On din_valid: register din_data into synth_data_out -> WR_ISSUE.
- WR_ISSUE (1 cycle): write=1 with adr, sel and synth_data_out stable; advance; go to WR_WAIT or FINISH.
- Address wrap: at end of a section, adr returns to 0 and the select moves one-hot to the next section. After the last m2 address -> FINISH.
- FINISH: done=1 for one cycle, busy drops, then IDLE.
- read and write are never high together. Selects are never high outside RD_ISSUE/RD_HOLD/WR_WAIT/WR_ISSUE.
- Reset mid-transfer: immediate return to reset values. A partial load is not undone.

Optional Feature:
PATCH_XFER_CHECKSUM_EN:
- Defined:
  - Dump appends one extra byte after the last register: (128 - (sum of all data bytes mod 128)) mod 128.
  - Load consumes one extra byte and compares it the same way. It issues no bus write for that byte.
  - Output csum_err (1 bit) is valid with done and cleared on the next start.
- Undefined: no extra byte, and the csum_err port is absent.

Decomposition:
- Package patch_xfer_pkg holds:
  - state enum (xfer_state_t);
  - section enum (SEC_COM, SEC_OSC, SEC_M1, SEC_M2);
  - per-section length function of V_OSC/COM_LEN;
  - total-length constant.
- Sub-module xfer_addr_gen: section/address counter with advance, wrap and last flags, plus one-hot select decode.

Test Plan:
- Dump with dout_ready tied high, responder at reset defaults:
  - byte 0 (com adr 0) = 0x00, byte 1 (m_vol) = 0x40;
  - byte 34 (osc adr 2, osc0 level) = 0x40;
  - 224 bytes total, then done pulses once.
- Dump with dout_ready toggling at random -> dout_data stable while valid && !ready; no lost or duplicated bytes; read pulses exactly 224 times.
- Load of bytes 0..223 (value = index) with random din_valid gaps, then dump -> written addresses read back the same values; write pulses exactly 224 times.
- Boundary: last com adr 31 is followed by osc_sel with adr 0; osc adr 63 is followed by m1_sel with adr 0; sel stays one-hot throughout.
- dump_start and load_start together -> dump runs. load_start during busy -> ignored.
- Reset asserted at byte 100 of a load -> all outputs 0 asynchronously. A new dump_start after release starts again at com adr 0.

Source files
------------

// File: rtl/patch_xfer_pkg.sv
// patch_xfer_pkg: shared types and sizing helpers for the patch transfer
// master. Holds the transfer FSM state type, the register-bus section type,
// the per-section length function and the default total transfer length.
package patch_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_HOLD,
    WR_WAIT,
    WR_ISSUE,
    FINISH
  } xfer_state_t;

  // Walk order of the register file; the encoding doubles as the one-hot
  // select bit position.
  typedef enum logic [1:0] {
    SEC_COM,
    SEC_OSC,
    SEC_M1,
    SEC_M2
  } sec_t;

  localparam int V_OSC_DEF   = 4;
  localparam int COM_LEN_DEF = 32;

  function automatic int sec_len(sec_t s, int v_osc, int com_len);
    return (s == SEC_COM) ? com_len : v_osc * 16;
  endfunction

  function automatic int total_len(int v_osc, int com_len);
    return com_len + 3 * v_osc * 16;
  endfunction

  localparam int XFER_TOTAL = total_len(V_OSC_DEF, COM_LEN_DEF);

endpackage

// File: rtl/patch_xfer_master_if.sv
// patch_xfer_master_if: mixer/synth control register bus.
//   adr            register address within the selected section
//   write / read   one-cycle strobes, never high together
//   com/osc/m1/m2  one-hot section selects, all low when idle
//   synth_data_out write data toward the register file
//   regdata_in     read data returned by the register file
interface patch_xfer_master_if;
  logic [6:0] adr;
  logic       write;
  logic       read;
  logic       com_sel;
  logic       osc_sel;
  logic       m1_sel;
  logic       m2_sel;
  logic [7:0] synth_data_out;
  logic [7:0] regdata_in;

  modport master (
    output adr, write, read, com_sel, osc_sel, m1_sel, m2_sel, synth_data_out,
    input  regdata_in
  );

  modport slave (
    input  adr, write, read, com_sel, osc_sel, m1_sel, m2_sel, synth_data_out,
    output regdata_in
  );
endinterface

// File: rtl/patch_xfer_master_addr_gen.sv
// xfer_addr_gen: section/address walker for the patch transfer master.
//   reg_clk, reset_reg_n  clock and asynchronous active-low reset
//   clear                 restart the walk at com adr 0
//   advance               step to the next register (wraps section by section)
//   sel_en                enables the one-hot select decode
//   adr                   address within the current section
//   last                  current register is the final m2 address
//   sel_onehot            {m2, m1, osc, com} selects
module xfer_addr_gen
  import patch_xfer_pkg::*;
#(
  parameter int V_OSC   = 4,
  parameter int COM_LEN = 32
) (
  input  logic       reg_clk,
  input  logic       reset_reg_n,
  input  logic       clear,
  input  logic       advance,
  input  logic       sel_en,
  output logic [6:0] adr,
  output logic       last,
  output logic [3:0] sel_onehot
);

  sec_t       sec;
  logic [6:0] sec_end;
  logic       sec_last;

  always_comb begin
    sec_end  = 7'(sec_len(sec, V_OSC, COM_LEN) - 1);
    sec_last = (adr == sec_end);
    last     = sec_last && (sec == SEC_M2);
  end

  always_ff @(posedge reg_clk or negedge reset_reg_n) begin
    if (!reset_reg_n) begin
      sec <= SEC_COM;
      adr <= '0;
    end else if (clear) begin
      sec <= SEC_COM;
      adr <= '0;
    end else if (advance) begin
      if (sec_last) begin
        adr <= '0;
        sec <= (sec == SEC_M2) ? SEC_COM : sec_t'(sec + 2'd1);
      end else begin
        adr <= adr + 7'd1;
      end
    end
  end

  assign sel_onehot = sel_en ? (4'b0001 << sec) : 4'b0000;

endmodule

// File: rtl/patch_xfer_master.sv
// patch_xfer_master: register-bus initiator that dumps the whole per-voice
// control register file onto a byte stream (com, osc, m1, m2 order) or loads
// it back from a byte stream with one bus write per byte.
//   reg_clk, reset_reg_n      clock, asynchronous active-low reset
//   dump_start, load_start    one-cycle start pulses (dump wins on a tie)
//   busy, done                transfer in progress / one-cycle completion
//   dout_data/valid/ready     dump byte stream
//   din_data/valid/ready      load byte stream
//   bus                       register bus (patch_xfer_master_if.master)
//   csum_err                  checksum mismatch, valid with done
//                             (only with PATCH_XFER_CHECKSUM_EN)
// Build option PATCH_XFER_CHECKSUM_EN appends/consumes one checksum byte.
module patch_xfer_master
  import patch_xfer_pkg::*;
#(
  parameter int V_OSC   = 4,
  parameter int COM_LEN = 32
) (
  input  logic       reg_clk,
  input  logic       reset_reg_n,
  input  logic       dump_start,
  input  logic       load_start,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout_data,
  output logic       dout_valid,
  input  logic       dout_ready,
  input  logic [7:0] din_data,
  input  logic       din_valid,
  output logic       din_ready,
`ifdef PATCH_XFER_CHECKSUM_EN
  output logic       csum_err,
`endif
  patch_xfer_master_if.master bus
);

`ifdef PATCH_XFER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  xfer_state_t state, nxt;
  logic        adv, clr, sel_en, rd, wr, hs, last;
  logic [3:0]  sel_onehot;
  logic        csum_phase;
  logic [7:0]  csum_byte;

  xfer_addr_gen #(.V_OSC(V_OSC), .COM_LEN(COM_LEN)) u_addr_gen (
    .reg_clk    (reg_clk),
    .reset_reg_n(reset_reg_n),
    .clear      (clr),
    .advance    (adv),
    .sel_en     (sel_en),
    .adr        (bus.adr),
    .last       (last),
    .sel_onehot (sel_onehot)
  );

  assign hs = dout_valid && dout_ready;

  always_ff @(posedge reg_clk or negedge reset_reg_n) begin
    if (!reset_reg_n) state <= IDLE;
    else              state <= nxt;
  end

  always_comb begin
    nxt       = state;
    adv       = 1'b0;
    clr       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    din_ready = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    sel_en    = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          nxt = RD_ISSUE;
          clr = 1'b1;
        end else if (load_start) begin
          nxt = WR_WAIT;
          clr = 1'b1;
        end
      end
      RD_ISSUE: begin
        busy   = 1'b1;
        sel_en = 1'b1;
        rd     = 1'b1;
        nxt    = RD_HOLD;
      end
      RD_HOLD: begin
        busy   = 1'b1;
        sel_en = 1'b1;
        if (hs) begin
          if (csum_phase) begin
            nxt = FINISH;
          end else begin
            adv = 1'b1;
            // With the checksum enabled, stay here to present the extra byte.
            if (!last)       nxt = RD_ISSUE;
            else if (CSUM_EN) nxt = RD_HOLD;
            else             nxt = FINISH;
          end
        end
      end
      WR_WAIT: begin
        busy      = 1'b1;
        sel_en    = 1'b1;
        din_ready = 1'b1;
        if (din_valid) nxt = csum_phase ? FINISH : WR_ISSUE;
      end
      WR_ISSUE: begin
        busy   = 1'b1;
        sel_en = 1'b1;
        wr     = 1'b1;
        adv    = 1'b1;
        nxt    = (last && !CSUM_EN) ? FINISH : WR_WAIT;
      end
      FINISH: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Read data is captured at the end of the read cycle, so it is on the
  // stream from the first RD_HOLD cycle and held until the handshake.
  always_ff @(posedge reg_clk or negedge reset_reg_n) begin
    if (!reset_reg_n) begin
      dout_data          <= '0;
      dout_valid         <= 1'b0;
      bus.synth_data_out <= '0;
    end else begin
      if (state == RD_ISSUE) begin
        dout_data  <= bus.regdata_in;
        dout_valid <= 1'b1;
      end else if (state == RD_HOLD && hs) begin
        if (CSUM_EN && last && !csum_phase) begin
          dout_data  <= csum_byte;
          dout_valid <= 1'b1;
        end else begin
          dout_valid <= 1'b0;
        end
      end
      if (state == WR_WAIT && din_valid && !csum_phase)
        bus.synth_data_out <= din_data;
    end
  end

`ifdef PATCH_XFER_CHECKSUM_EN
  logic [6:0] sum;

  // Two's complement of the 7-bit running sum: (128 - sum mod 128) mod 128.
  assign csum_byte = {1'b0, 7'(7'd0 - sum)};

  always_ff @(posedge reg_clk or negedge reset_reg_n) begin
    if (!reset_reg_n) begin
      sum        <= '0;
      csum_phase <= 1'b0;
      csum_err   <= 1'b0;
    end else begin
      if (state == IDLE && (dump_start || load_start)) begin
        sum        <= '0;
        csum_phase <= 1'b0;
        csum_err   <= 1'b0;
      end
      if (state == RD_ISSUE)
        sum <= sum + bus.regdata_in[6:0];
      if (state == WR_WAIT && din_valid && !csum_phase)
        sum <= sum + din_data[6:0];
      if ((state == RD_HOLD && hs && last) || (state == WR_ISSUE && last))
        csum_phase <= 1'b1;
      if (state == WR_WAIT && din_valid && csum_phase)
        csum_err <= (din_data != csum_byte);
      if (state == FINISH)
        csum_phase <= 1'b0;
    end
  end
`else
  assign csum_phase = 1'b0;
  assign csum_byte  = 8'h00;
`endif

  assign bus.read  = rd;
  assign bus.write = wr;
  assign {bus.m2_sel, bus.m1_sel, bus.osc_sel, bus.com_sel} = sel_onehot;

endmodule

// File: tb/tb_patch_xfer_master.sv
module tb_patch_xfer_master;
  localparam int N = 224;

  logic       reg_clk, reset_reg_n;
  logic       dump_start, load_start, busy, done;
  logic [7:0] dout_data, din_data;
  logic       dout_valid, dout_ready, din_valid, din_ready;
`ifdef PATCH_XFER_CHECKSUM_EN
  logic       csum_err;
`endif

  patch_xfer_master_if bus ();

  patch_xfer_master dut (
    .reg_clk    (reg_clk),
    .reset_reg_n(reset_reg_n),
    .dump_start (dump_start),
    .load_start (load_start),
    .busy       (busy),
    .done       (done),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .din_data   (din_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
`ifdef PATCH_XFER_CHECKSUM_EN
    .csum_err   (csum_err),
`endif
    .bus        (bus.master)
  );

  initial begin
    reg_clk = 1'b0;
    forever #5 reg_clk = ~reg_clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Register-file image (responder) and the bench's expected image.
  logic [7:0] mem [N];
  logic [7:0] exp_mem [N];
  logic [7:0] load_vals [N];

  function automatic logic [7:0] default_val(int i);
    int j, s, a;
    if (i < 32) return (i == 1) ? 8'h40 : 8'(i);
    j = i - 32; s = j / 64; a = j % 64;
    if (s == 0) return (a % 16 == 2) ? 8'h40 : 8'(16 + a);
    if (s == 1) return 8'(128 + a);
    return 8'(192 - a);
  endfunction

  // Expected {sel, adr} of the i-th register in walk order.
  function automatic logic [10:0] exp_bus(int i);
    logic [3:0] s;
    int j;
    if (i < 32) return {4'b0001, 7'(i)};
    j = i - 32;
    s = 4'b0010 << (j / 64);
    return {s, 7'(j % 64)};
  endfunction

  function automatic int bus_idx(logic [3:0] s, logic [6:0] a);
    case (s)
      4'b0001: return (a < 32) ? int'(a) : -1;
      4'b0010: return (a < 64) ? 32 + int'(a) : -1;
      4'b0100: return (a < 64) ? 96 + int'(a) : -1;
      4'b1000: return (a < 64) ? 160 + int'(a) : -1;
      default: return -1;
    endcase
  endfunction

  // Monitor state, sampled on the falling edge.
  logic [10:0] rd_q [$];
  logic [18:0] wr_q [$];
  logic [7:0]  dump_q [$];
  int rd_cnt, wr_cnt, done_cnt, sel_viol, rw_viol, busy_done_viol, stall_viol, bad_adr, rdy_cnt;
  logic [3:0] mon_sels;
  logic       prev_valid, prev_ready;
  logic [7:0] prev_data;
  int         widx;

  task automatic clear_logs();
    rd_q.delete(); wr_q.delete(); dump_q.delete();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; sel_viol = 0; rw_viol = 0;
    busy_done_viol = 0; stall_viol = 0; bad_adr = 0; rdy_cnt = 0;
  endtask

  always @(negedge reg_clk) begin
    if (reset_reg_n) begin
      mon_sels = {bus.m2_sel, bus.m1_sel, bus.osc_sel, bus.com_sel};
      if (bus.read) begin
        rd_q.push_back({mon_sels, bus.adr});
        rd_cnt++;
        widx = bus_idx(mon_sels, bus.adr);
        if (widx < 0) bad_adr++;
        else bus.regdata_in = mem[widx];
      end
      if (bus.write) begin
        wr_q.push_back({mon_sels, bus.adr, bus.synth_data_out});
        wr_cnt++;
        widx = bus_idx(mon_sels, bus.adr);
        if (widx < 0) bad_adr++;
        else mem[widx] = bus.synth_data_out;
      end
      if (bus.read && bus.write) rw_viol++;
      if (busy ? !$onehot(mon_sels) : (mon_sels != 4'b0000)) sel_viol++;
      if (done) begin
        done_cnt++;
        if (busy) busy_done_viol++;
      end
      if (din_ready) rdy_cnt++;
      if (prev_valid && !prev_ready && !(dout_valid && dout_data == prev_data)) stall_viol++;
      if (dout_valid && dout_ready) dump_q.push_back(dout_data);
      prev_valid = dout_valid;
      prev_ready = dout_ready;
      prev_data  = dout_data;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Downstream ready: tied high or random per cycle.
  bit ready_rand = 1'b0;
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge reg_clk); #1;
      dout_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic pulse_start(input logic d, input logic l);
    dump_start = d; load_start = l;
    @(posedge reg_clk); #1;
    dump_start = 1'b0; load_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge reg_clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk({name, "_done_seen"}, ok, 1);
    @(posedge reg_clk); #1;
  endtask

  task automatic feed_load(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge reg_clk); #1;
      end
      din_data = load_vals[i]; din_valid = 1'b1; ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge reg_clk);
        if (!reset_reg_n) begin din_valid = 1'b0; return; end
        if (din_ready) begin ok = 1'b1; break; end
      end
      @(posedge reg_clk); #1;
      din_valid = 1'b0;
      if (!ok) begin
        chk("load_byte_accept_timeout", i, -1);
        return;
      end
    end
  endtask

  task automatic check_dump(input string name);
    int bad_data = 0, bad_order = 0;
    chk({name, "_bytes"}, dump_q.size(), N);
    chk({name, "_reads"}, rd_cnt, N);
    chk({name, "_done_pulses"}, done_cnt, 1);
    for (int i = 0; i < dump_q.size() && i < N; i++)
      if (dump_q[i] !== exp_mem[i]) bad_data++;
    for (int i = 0; i < rd_q.size() && i < N; i++)
      if (rd_q[i] !== exp_bus(i)) bad_order++;
    chk({name, "_data_mismatches"}, bad_data, 0);
    chk({name, "_order_mismatches"}, bad_order, 0);
    chk({name, "_sel_violations"}, sel_viol, 0);
    chk({name, "_rw_overlap"}, rw_viol, 0);
    chk({name, "_busy_with_done"}, busy_done_viol, 0);
    chk({name, "_stall_violations"}, stall_viol, 0);
    chk({name, "_bad_adr"}, bad_adr, 0);
  endtask

  task automatic run_dump(input string name, input bit rnd);
    clear_logs();
    ready_rand = rnd;
    pulse_start(1'b1, 1'b0);
    wait_done(name);
    repeat (3) @(posedge reg_clk);
    #1;
    check_dump(name);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_dout_valid"}, dout_valid, 0);
    chk({name, "_dout_data"}, dout_data, 0);
    chk({name, "_din_ready"}, din_ready, 0);
    chk({name, "_read"}, bus.read, 0);
    chk({name, "_write"}, bus.write, 0);
    chk({name, "_sels"}, {bus.m2_sel, bus.m1_sel, bus.osc_sel, bus.com_sel}, 0);
    chk({name, "_adr"}, bus.adr, 0);
    chk({name, "_synth_data_out"}, bus.synth_data_out, 0);
  endtask

  typedef struct {
    int         idx;
    logic [3:0] sel;
    logic [6:0] adr;
    logic [7:0] data;
  } vec_t;
  vec_t tbl [10];

  initial begin
    reset_reg_n = 1'b0;
    dump_start = 1'b0; load_start = 1'b0;
    din_data = 8'h00; din_valid = 1'b0;
    bus.regdata_in = 8'h00;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      mem[i] = default_val(i);
      exp_mem[i] = mem[i];
    end
    tbl[0] = '{0,   4'b0001, 7'd0,  8'h00};
    tbl[1] = '{1,   4'b0001, 7'd1,  8'h40};
    tbl[2] = '{31,  4'b0001, 7'd31, 8'h1F};
    tbl[3] = '{32,  4'b0010, 7'd0,  8'h10};
    tbl[4] = '{34,  4'b0010, 7'd2,  8'h40};
    tbl[5] = '{95,  4'b0010, 7'd63, 8'h4F};
    tbl[6] = '{96,  4'b0100, 7'd0,  8'h80};
    tbl[7] = '{159, 4'b0100, 7'd63, 8'hBF};
    tbl[8] = '{160, 4'b1000, 7'd0,  8'hC0};
    tbl[9] = '{223, 4'b1000, 7'd63, 8'h81};

    repeat (3) @(posedge reg_clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge reg_clk);
    reset_reg_n = 1'b1;
    @(posedge reg_clk); #1;

    // Dump of the default image, ready tied high.
    run_dump("dump_rdy_hi", 1'b0);
    for (int k = 0; k < 10; k++) begin
      logic [10:0] got_bus;
      logic [7:0]  got_data;
      got_bus  = (tbl[k].idx < rd_q.size()) ? rd_q[tbl[k].idx] : 11'h7FF;
      got_data = (tbl[k].idx < dump_q.size()) ? dump_q[tbl[k].idx] : 8'hXX;
      chk($sformatf("tbl_bus_idx%0d", tbl[k].idx), got_bus, {tbl[k].sel, tbl[k].adr});
      chk($sformatf("tbl_data_idx%0d", tbl[k].idx), got_data, tbl[k].data);
    end

    // Dump with random backpressure.
    run_dump("dump_rdy_rand", 1'b1);

    // Load of index values with random gaps, then read back.
    for (int i = 0; i < N; i++) load_vals[i] = 8'(i);
    clear_logs();
    ready_rand = 1'b0;
    pulse_start(1'b0, 1'b1);
    feed_load(N);
    wait_done("load");
    repeat (2) @(posedge reg_clk);
    #1;
    begin
      int bad_wr = 0, bad_mem = 0;
      chk("load_writes", wr_cnt, N);
      chk("load_reads", rd_cnt, 0);
      chk("load_done_pulses", done_cnt, 1);
      for (int i = 0; i < wr_q.size() && i < N; i++)
        if (wr_q[i] !== {exp_bus(i), load_vals[i]}) bad_wr++;
      chk("load_write_mismatches", bad_wr, 0);
      chk("load_sel_violations", sel_viol, 0);
      for (int i = 0; i < N; i++) exp_mem[i] = load_vals[i];
      for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) bad_mem++;
      chk("load_regfile_mismatches", bad_mem, 0);
    end
    run_dump("dump_after_load", 1'b1);

    // Simultaneous starts: dump wins.
    clear_logs();
    ready_rand = 1'b0;
    pulse_start(1'b1, 1'b1);
    @(negedge reg_clk);
    chk("both_start_read", bus.read, 1);
    chk("both_start_din_ready", din_ready, 0);
    wait_done("both_start");
    repeat (3) @(posedge reg_clk);
    #1;
    chk("both_start_writes", wr_cnt, 0);
    chk("both_start_din_ready_cycles", rdy_cnt, 0);
    check_dump("both_start");

    // load_start while busy is ignored.
    clear_logs();
    ready_rand = 1'b1;
    pulse_start(1'b1, 1'b0);
    repeat (20) @(posedge reg_clk);
    #1;
    load_start = 1'b1;
    @(posedge reg_clk); #1;
    load_start = 1'b0;
    wait_done("busy_load");
    repeat (5) @(posedge reg_clk);
    #1;
    chk("busy_load_idle_after", busy, 0);
    chk("busy_load_writes", wr_cnt, 0);
    chk("busy_load_din_ready_cycles", rdy_cnt, 0);
    check_dump("busy_load");

    // Reset in the middle of a load.
    for (int i = 0; i < N; i++) load_vals[i] = 8'hA5 ^ 8'(i);
    clear_logs();
    ready_rand = 1'b0;
    pulse_start(1'b0, 1'b1);
    fork
      feed_load(N);
    join_none
    begin
      bit hit = 1'b0;
      for (int t = 0; t < 3000; t++) begin
        @(negedge reg_clk);
        if (wr_cnt >= 100) begin hit = 1'b1; break; end
      end
      chk("midload_reached_100", hit, 1);
    end
    @(posedge reg_clk); #3;
    reset_reg_n = 1'b0;
    #1;
    chk("midload_writes_before_reset", wr_cnt, 100);
    chk_outputs_zero("midload_reset");
    repeat (3) @(posedge reg_clk);
    #1;
    din_valid = 1'b0;
    for (int i = 0; i < 100; i++) exp_mem[i] = load_vals[i];
    @(negedge reg_clk);
    reset_reg_n = 1'b1;
    @(posedge reg_clk); #1;
    run_dump("dump_after_reset", 1'b0);
    chk("dump_after_reset_first_bus", (rd_q.size() > 0) ? rd_q[0] : 11'h7FF, 11'b0001_0000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
